led_arbiter: RTL and testbench

Shares the board RGB status LED between up to N_REQ requesters and drives its active-low r/g/b pins. Grants by fixed priority with a minimum hold time, latches the winner's colour and blink mode, and blinks it from a shared tick prescaler. With no requester it runs the idle R→G→B rotation. Sits between status sources (UART, bus monitor, fault logic) and the LED pins.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_arbiter_if.sv | 14 +
 rtl/led_tick.sv | 20 ++
 rtl/led_arbiter.sv | 88 ++++++++
 tb/tb_led_arbiter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, colour constants and priority encoder for the LED arbiter
package led_pkg;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  localparam logic [2:0] LED_OFF    = 3'b000;
  localparam logic [2:0] LED_R      = 3'b001;
  localparam logic [2:0] LED_G      = 3'b010;
  localparam logic [2:0] LED_B      = 3'b100;
  localparam logic [2:0] IDLE_RESET = LED_R;

  // Lowest set index wins; returns 0 for an all-zero vector.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/led_arbiter_if.sv
// rtl/led_arbiter_if.sv - requester bundle and LED pins of the arbiter
interface led_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]   req;
  logic [3*N_REQ-1:0] req_color;
  logic [N_REQ-1:0]   req_blink;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               r;
  logic               g;
  logic               b;

  modport master (output req, req_color, req_blink, input grant, busy, r, g, b);
  modport slave  (input req, req_color, req_blink, output grant, busy, r, g, b);
endinterface

// File: rtl/led_tick.sv
// rtl/led_tick.sv - free-running prescaler, tick high for one clk every TICK_DIV cycles
module led_tick #(
  parameter logic [31:0] TICK_DIV = 32'd12000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [31:0] cnt;

  assign tick = (cnt == TICK_DIV - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= 32'd0;
    else if (tick) cnt <= 32'd0;
    else           cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - fixed-priority owner of the RGB status LED with hold time, blink and idle rotation
module led_arbiter
  import led_pkg::*;
#(
  parameter int          N_REQ      = 4,
  parameter logic [31:0] TICK_DIV   = 32'd12000000,
  parameter int          HOLD_TICKS = 2
) (
  input  logic          clk,
  input  logic          rst,
  led_arbiter_if.slave  bus
);

  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  state_t        state;
  logic [2:0]    idle_step;
  logic [2:0]    owner;
  logic [HW-1:0] hold;
  logic          phase;
  logic [2:0]    colour;
  logic          blink;

  logic          tick;
  logic [7:0]    req_ext;
  logic [7:0]    blink_ext;
  logic [23:0]   color_ext;
  logic [7:0]    above_owner;
  logic [2:0]    win;
  logic          any_req;
  logic          reeval;
  logic          load;
  logic [2:0]    led;

  led_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign req_ext     = 8'(bus.req);
  assign blink_ext   = 8'(bus.req_blink);
  assign color_ext   = 24'(bus.req_color);
  assign above_owner = (8'd1 << owner) - 8'd1;
  assign win         = lowest_set(req_ext);
  assign any_req     = |req_ext;
  assign reeval      = !req_ext[owner] || (hold == '0 && |(req_ext & above_owner));
  assign load        = any_req && (state == ST_IDLE || reeval);

  // Grants and re-evaluations take precedence over the tick in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idle_step <= IDLE_RESET;
      owner     <= 3'd0;
      hold      <= '0;
      phase     <= 1'b1;
      colour    <= LED_OFF;
      blink     <= 1'b0;
    end else if (load) begin
      state  <= ST_OWNED;
      owner  <= win;
      hold   <= HW'(HOLD_TICKS);
      phase  <= 1'b1;
      colour <= color_ext[3*int'(win) +: 3];
      blink  <= blink_ext[win];
    end else if (state == ST_OWNED && reeval) begin
      state     <= ST_IDLE;
      idle_step <= IDLE_RESET;
      phase     <= 1'b1;
    end else if (tick) begin
      if (state == ST_IDLE) begin
        idle_step <= {idle_step[1:0], idle_step[2]};
      end else begin
        if (blink)      phase <= ~phase;
        if (hold != '0) hold  <= hold - HW'(1);
      end
    end
  end

  assign led       = (state == ST_OWNED) ? (colour & {3{phase | ~blink}}) : idle_step;
  assign bus.busy  = (state == ST_OWNED);
  assign bus.grant = bus.busy ? N_REQ'(8'd1 << owner) : '0;
  assign bus.r     = ~led[0];
  assign bus.g     = ~led[1];
  assign bus.b     = ~led[2];

endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - table-driven scoreboard bench for led_arbiter (N_REQ=4, TICK_DIV=4, HOLD_TICKS=2)
module tb_led_arbiter;

  typedef struct {
    bit          rst_first;
    logic [3:0]  req;
    logic [11:0] color;
    logic [3:0]  blink;
    logic [3:0]  grant;
    logic        busy;
    logic [2:0]  rgb;
    string       name;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  exp_t sb[$];

  led_arbiter_if #(.N_REQ(4)) bus ();

  led_arbiter #(.N_REQ(4), .TICK_DIV(32'd4), .HOLD_TICKS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] observed();
    return {bus.grant, bus.busy, bus.r, bus.g, bus.b};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got grant/busy/rgb=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input bit rf, input logic [3:0] rq, input logic [11:0] col, input logic [3:0] bl,
                     input logic [3:0] gr, input logic bz, input logic [2:0] rgb, input string nm);
    vec_t v;
    v.rst_first = rf; v.req = rq; v.color = col; v.blink = bl;
    v.grant = gr; v.busy = bz; v.rgb = rgb; v.name = nm;
    tbl.push_back(v);
  endtask

  // Entry c is driven in cycle c (cnt == c mod 4 after reset); its expectation is cycle c+1.
  initial begin
    exp_t e;
    bus.req = '0; bus.req_color = '0; bus.req_blink = '0;

    // idle rotation: R cycles 0-3, G 4-7, B 8-11, R again from 12
    for (int c = 0; c <= 12; c++)
      add(c == 0, 4'b0000, 12'h0, 4'h0, 4'b0000, 1'b0,
          (c <= 2) ? 3'b011 : (c <= 6) ? 3'b101 : (c <= 10) ? 3'b110 : 3'b011, "idle");
    // solid grant, colour changes while held are ignored
    add(1, 4'b0100, 12'b000_110_000_000, 4'h0, 4'b0100, 1'b1, 3'b100, "solid");
    add(0, 4'b0100, 12'b000_001_000_000, 4'h0, 4'b0100, 1'b1, 3'b100, "solid_latch1");
    add(0, 4'b0100, 12'b000_111_000_000, 4'h0, 4'b0100, 1'b1, 3'b100, "solid_latch2");
    add(0, 4'b0100, 12'b000_111_000_000, 4'b0100, 4'b0100, 1'b1, 3'b100, "solid_latch3");
    // blink red: lit cycles 1-3, dark 4-7, lit 8-11
    for (int c = 0; c <= 9; c++)
      add(c == 0, 4'b0010, 12'b000_000_001_000, 4'b0010, 4'b0010, 1'b1,
          (c <= 2 || c >= 7) ? 3'b011 : 3'b111, "blink");
    // hold and preempt: ticks in cycles 3 and 7, reeval in cycle 8, new owner seen in cycle 9
    add(1, 4'b1000, 12'b100_000_000_001, 4'h0, 4'b1000, 1'b1, 3'b110, "hold");
    for (int c = 1; c <= 9; c++)
      add(0, 4'b1001, 12'b100_000_000_001, 4'h0, (c <= 7) ? 4'b1000 : 4'b0001, 1'b1,
          (c <= 7) ? 3'b110 : 3'b011, (c <= 7) ? "hold" : "preempt");
    // release: back to idle at R, rotation follows the free-running prescaler
    add(1, 4'b0001, 12'b000_000_000_010, 4'h0, 4'b0001, 1'b1, 3'b101, "release_own");
    add(0, 4'b0000, 12'b000_000_000_010, 4'h0, 4'b0000, 1'b0, 3'b011, "release");
    add(0, 4'b0000, 12'h0, 4'h0, 4'b0000, 1'b0, 3'b011, "release_idle_r");
    add(0, 4'b0000, 12'h0, 4'h0, 4'b0000, 1'b0, 3'b101, "release_idle_g");
    // priority and owner drop with a lower-priority requester present
    add(1, 4'b0110, 12'b000_100_010_000, 4'h0, 4'b0010, 1'b1, 3'b101, "priority");
    add(0, 4'b0100, 12'b000_100_010_000, 4'h0, 4'b0100, 1'b1, 3'b110, "drop_regrant");
    add(0, 4'b0100, 12'b000_100_010_000, 4'h0, 4'b0100, 1'b1, 3'b110, "drop_hold");

    foreach (tbl[i]) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.name, observed(), e.exp);
      end
      if (tbl[i].rst_first) begin
        rst = 1'b0;
        bus.req = '0; bus.req_color = '0; bus.req_blink = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("reset_state", observed(), 8'b0000_0_011);
      end
      bus.req = tbl[i].req;
      bus.req_color = tbl[i].color;
      bus.req_blink = tbl[i].blink;
      e.name = tbl[i].name;
      e.exp  = {tbl[i].grant, tbl[i].busy, tbl[i].rgb};
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.name, observed(), e.exp);
    end

    // asynchronous reset while owning a blinking colour
    rst = 1'b0;
    bus.req = '0; bus.req_color = '0; bus.req_blink = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.req = 4'b0010; bus.req_color = 12'b000_000_001_000; bus.req_blink = 4'b0010;
    repeat (6) @(negedge clk);
    chk("blink_dark", observed(), 8'b0010_1_111);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst", observed(), 8'b0000_0_011);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", observed(), 8'b0000_0_011);

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
